// File: rtl/punch_anim_sequencer.sv
// Punch animation sequencer: steps the fighter sprite through idle/punch frames on
// OLED frame ticks and composites the selected sprite over the background.
`timescale 1ns/1ps
module punch_anim_sequencer #(
  parameter int unsigned HOLD_WINDUP   = 2,
  parameter int unsigned HOLD_EXTEND   = 1,
  parameter int unsigned HOLD_STRIKE   = 3,
  parameter int unsigned HOLD_RETRACT  = 1,
  parameter int unsigned HOLD_COOLDOWN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        punch_req,
  input  logic [12:0] pixel_index,
  input  logic [15:0] idle_colour,
  input  logic [15:0] p1_colour,
  input  logic [15:0] p2_colour,
  input  logic [15:0] p3_colour,
  input  logic [15:0] bg_colour,
  output logic [15:0] oled_colour,
  output logic [1:0]  frame_sel,
  output logic        busy,
  output logic        hit_active,
  output logic        punch_done
);

  // state      | meaning
  // S_IDLE     | idle stance, waiting for punch_req
  // S_WINDUP   | frame 1, arm drawn back
  // S_EXTEND   | frame 2, arm travelling out
  // S_STRIKE   | frame 3, hit window open
  // S_RETRACT  | frame 2, arm travelling back
  // S_COOLDOWN | idle stance, new punch blocked until exit
  typedef enum logic [2:0] {
    S_IDLE, S_WINDUP, S_EXTEND, S_STRIKE, S_RETRACT, S_COOLDOWN
  } state_t;

  localparam logic [7:0] LAST_WINDUP   = 8'(HOLD_WINDUP - 1);
  localparam logic [7:0] LAST_EXTEND   = 8'(HOLD_EXTEND - 1);
  localparam logic [7:0] LAST_STRIKE   = 8'(HOLD_STRIKE - 1);
  localparam logic [7:0] LAST_RETRACT  = 8'(HOLD_RETRACT - 1);
  localparam logic [7:0] LAST_COOLDOWN = 8'(HOLD_COOLDOWN - 1);

  state_t      state_q, state_d;
  logic [7:0]  tick_q, tick_d;
  logic        pending_q, pending_d;
  logic        done_d;
  logic [7:0]  hold_last;
  logic        last_tick;
  logic [15:0] sel_col;
  logic [15:0] oled_d;

  // Sprite ROMs are addressed outside this block; pixel_index only rides along.
  logic unused_pixel_index;
  assign unused_pixel_index = ^pixel_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tick_q      <= 8'd0;
      pending_q   <= 1'b0;
      punch_done  <= 1'b0;
      oled_colour <= 16'h0000;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      pending_q   <= pending_d;
      punch_done  <= done_d;
      oled_colour <= oled_d;
    end
  end

  always_comb begin
    hold_last = 8'd0;
    case (state_q)
      S_WINDUP:   hold_last = LAST_WINDUP;
      S_EXTEND:   hold_last = LAST_EXTEND;
      S_STRIKE:   hold_last = LAST_STRIKE;
      S_RETRACT:  hold_last = LAST_RETRACT;
      S_COOLDOWN: hold_last = LAST_COOLDOWN;
      default:    hold_last = 8'd0;
    endcase
  end

  assign last_tick = frame_tick && (tick_q == hold_last);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    if (state_q == S_IDLE) begin
      // A tick coinciding with the accepted request is not counted.
      if (punch_req) begin
        state_d = S_WINDUP;
        tick_d  = 8'd0;
      end
    end else begin
      if (punch_req) pending_d = 1'b1;
      if (frame_tick) tick_d = tick_q + 8'd1;
      if (last_tick) begin
        tick_d = 8'd0;
        case (state_q)
          S_WINDUP:  state_d = S_EXTEND;
          S_EXTEND:  state_d = S_STRIKE;
          S_STRIKE:  state_d = S_RETRACT;
          S_RETRACT: state_d = S_COOLDOWN;
          S_COOLDOWN: begin
            done_d    = 1'b1;
            pending_d = 1'b0;
            state_d   = (pending_q || punch_req) ? S_WINDUP : S_IDLE;
          end
          default:   state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    frame_sel  = 2'd0;
    busy       = (state_q != S_IDLE);
    hit_active = (state_q == S_STRIKE);
    case (state_q)
      S_WINDUP:  frame_sel = 2'd1;
      S_EXTEND:  frame_sel = 2'd2;
      S_STRIKE:  frame_sel = 2'd3;
      S_RETRACT: frame_sel = 2'd2;
      default:   frame_sel = 2'd0;
    endcase
    case (frame_sel)
      2'd1:    sel_col = p1_colour;
      2'd2:    sel_col = p2_colour;
      2'd3:    sel_col = p3_colour;
      default: sel_col = idle_colour;
    endcase
    oled_d = (sel_col == 16'h0000) ? bg_colour : sel_col;
  end

endmodule

// File: tb/tb_punch_anim_sequencer.sv
// Scoreboard bench for punch_anim_sequencer: a phase/ticks-remaining reference model
// predicts every cycle's outputs; a negedge monitor compares them against the DUT.
`timescale 1ns/1ps
module tb_punch_anim_sequencer;

  localparam int HOLD_TAB  [6] = '{0, 2, 1, 3, 1, 2};
  localparam int FRAME_TAB [6] = '{0, 1, 2, 3, 2, 0};
  localparam int SINGLE_SEQ [10] = '{1, 1, 2, 3, 3, 3, 2, 0, 0, 0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick, punch_req;
  logic [12:0] pixel_index;
  logic [15:0] idle_colour, p1_colour, p2_colour, p3_colour, bg_colour;
  logic [15:0] oled_colour;
  logic [1:0]  frame_sel;
  logic        busy, hit_active, punch_done;

  always #5 clk = ~clk;

  punch_anim_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .punch_req(punch_req),
    .pixel_index(pixel_index), .idle_colour(idle_colour), .p1_colour(p1_colour),
    .p2_colour(p2_colour), .p3_colour(p3_colour), .bg_colour(bg_colour),
    .oled_colour(oled_colour), .frame_sel(frame_sel), .busy(busy),
    .hit_active(hit_active), .punch_done(punch_done)
  );

  typedef struct packed {
    logic [1:0]  fs;
    logic        busy;
    logic        hit;
    logic        done;
    logic [15:0] oled;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   done_cnt = 0, hit_cnt = 0;
  bit   rand_col = 1'b1;

  int          m_ph = 0, m_left = 0;
  bit          m_pend = 1'b0, m_done = 1'b0;
  logic [15:0] m_oled = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rnd_col();
    return ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
  endfunction

  task automatic model_reset();
    m_ph = 0; m_left = 0; m_pend = 1'b0; m_done = 1'b0; m_oled = 16'h0000;
  endtask

  // Evaluated once per rising edge with the inputs the driver applied for that edge.
  task automatic model_step();
    exp_t        e;
    logic [15:0] sel;
    if (!rst_n) begin
      model_reset();
    end else begin
      case (FRAME_TAB[m_ph])
        1:       sel = p1_colour;
        2:       sel = p2_colour;
        3:       sel = p3_colour;
        default: sel = idle_colour;
      endcase
      m_oled = (sel == 16'h0000) ? bg_colour : sel;
      m_done = 1'b0;
      if (m_ph == 0) begin
        if (punch_req) begin m_ph = 1; m_left = HOLD_TAB[1]; end
      end else if (frame_tick && m_left == 1) begin
        if (m_ph == 5) begin
          m_done = 1'b1;
          if (m_pend || punch_req) begin m_ph = 1; m_left = HOLD_TAB[1]; end
          else m_ph = 0;
          m_pend = 1'b0;
        end else begin
          m_ph++;
          m_left = HOLD_TAB[m_ph];
          if (punch_req) m_pend = 1'b1;
        end
      end else begin
        if (frame_tick) m_left--;
        if (punch_req) m_pend = 1'b1;
      end
    end
    e.fs   = 2'(FRAME_TAB[m_ph]);
    e.busy = (m_ph != 0);
    e.hit  = (m_ph == 3);
    e.done = m_done;
    e.oled = m_oled;
    sb.push_back(e);
  endtask

  task automatic step(input logic req, input logic tick);
    @(negedge clk);
    #1;
    punch_req   = req;
    frame_tick  = tick;
    pixel_index = 13'($urandom_range(0, 6143));
    if (rand_col) begin
      idle_colour = rnd_col(); p1_colour = rnd_col(); p2_colour = rnd_col();
      p3_colour   = rnd_col(); bg_colour = rnd_col();
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      repeat (gap - 1) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    punch_req = 1'b1; frame_tick = 1'b1; rst_n = 1'b0;
    #1;
    chk("async_rst_frame_sel", frame_sel, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_hit", hit_active, 0);
    chk("async_rst_done", punch_done, 0);
    chk("async_rst_oled", oled_colour, 0);
    model_reset();
    sb.delete();
    repeat (n) step(1'b1, 1'b1);
    #2;
    rst_n = 1'b1; punch_req = 1'b0; frame_tick = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (punch_done) done_cnt++;
    if (hit_active) hit_cnt++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_frame_sel", frame_sel, e.fs);
      chk("sb_busy", busy, e.busy);
      chk("sb_hit_active", hit_active, e.hit);
      chk("sb_punch_done", punch_done, e.done);
      chk("sb_oled", oled_colour, e.oled);
    end
  end

  initial begin
    int seq [10];
    int snap;
    rst_n = 1'b0; punch_req = 1'b1; frame_tick = 1'b1; pixel_index = '0;
    idle_colour = '0; p1_colour = '0; p2_colour = '0; p3_colour = '0; bg_colour = '0;
    #1;
    chk("rst_frame_sel", frame_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_oled", oled_colour, 0);
    repeat (3) step(1'b1, 1'b1);
    #2;
    rst_n = 1'b1; punch_req = 1'b0; frame_tick = 1'b0;
    repeat (3) step(1'b0, 1'b1);
    #1 chk("post_rst_idle_frame", frame_sel, 0);

    // Single punch, ticks 100 clocks apart
    done_cnt = 0; hit_cnt = 0;
    step(1'b1, 1'b0);
    #1 seq[0] = int'(frame_sel);
    for (int k = 1; k <= 9; k++) begin
      repeat (99) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      #1 seq[k] = int'(frame_sel);
      if (k == 9) begin
        chk("single_done_pulse", punch_done, 1);
        chk("single_busy_drop", busy, 0);
      end
    end
    for (int k = 0; k < 10; k++) chk("single_frame_seq", seq[k], SINGLE_SEQ[k]);
    step(1'b0, 1'b0);
    #1 chk("single_done_one_cycle", punch_done, 0);
    chk("single_done_count", done_cnt, 1);
    chk("single_hit_cycles", hit_cnt, 300);

    // Buffered request during STRIKE, dropped one during RETRACT
    done_cnt = 0;
    step(1'b1, 1'b0);
    ticks(3, 5);
    #1 chk("buf_in_strike", frame_sel, 3);
    step(1'b1, 1'b0);
    ticks(3, 5);
    #1 chk("buf_in_retract", frame_sel, 2);
    step(1'b1, 1'b0);
    ticks(2, 5);
    repeat (4) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    #1 chk("buf_straight_to_windup", frame_sel, 1);
    chk("buf_first_done", punch_done, 1);
    ticks(9, 5);
    repeat (3) step(1'b0, 1'b0);
    chk("buf_done_count", done_cnt, 2);
    chk("buf_idle_after", busy, 0);

    // Request and tick together in IDLE
    step(1'b1, 1'b1);
    #1 chk("simul_enter_windup", frame_sel, 1);
    ticks(1, 5);
    #1 chk("simul_still_windup", frame_sel, 1);
    ticks(1, 5);
    #1 chk("simul_extend", frame_sel, 2);
    ticks(7, 5);
    repeat (3) step(1'b0, 1'b0);

    // Transparency in STRIKE, then reset mid-punch
    step(1'b1, 1'b0);
    ticks(3, 5);
    rand_col = 1'b0;
    p3_colour = 16'h0000; bg_colour = 16'h001F;
    step(1'b0, 1'b0);
    #1 chk("transp_bg", oled_colour, 16'h001F);
    p3_colour = 16'hF800;
    step(1'b0, 1'b0);
    #1 chk("transp_opaque", oled_colour, 16'hF800);
    rand_col = 1'b1;
    snap = done_cnt;
    do_reset(2);
    repeat (5) step(1'b0, 1'b1);
    chk("midrst_no_done", done_cnt, snap);
    #1 chk("midrst_idle", busy, 0);
    step(1'b1, 1'b0);
    #1 chk("midrst_restart_windup", frame_sel, 1);
    ticks(9, 5);

    // Random traffic
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 7) == 0));
    step(1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/punch_anim_sequencer.md
# punch_anim_sequencer

Sequences the fighter's punch animation by selecting which sprite frame ROM (idle stance, punch frames 1–3) drives the OLED pixel stream, and advancing frames on display-frame ticks. It sits between the per-frame sprite ROMs (pixel_index → RGB565, 0 = transparent) and the OLED compositor. It also applies transparency against the background and exposes hit-window and completion status to the game logic.

## Interface
- HOLD_WINDUP, 2: frame ticks spent showing frame 1
- HOLD_EXTEND, 1: ticks showing frame 2 on the way out
- HOLD_STRIKE, 3: ticks showing frame 3; the hit window
- HOLD_RETRACT, 1: ticks showing frame 2 on the way back
- HOLD_COOLDOWN, 2: ticks in idle stance before a new punch may start
- All HOLD_* values are 1..255. An 8-bit tick counter is used.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at the start of each OLED frame
- punch_req  in  1  one-cycle punch request pulse
- pixel_index  in  13  current OLED pixel (0..6143)
- idle_colour  in  16  idle-stance ROM output for pixel_index
- p1_colour, p2_colour, p3_colour  in  16 each  punch frame ROM outputs
- bg_colour  in  16  background colour for pixel_index
- oled_colour  out  16  composited pixel, registered
- frame_sel  out  2  0 = idle, 1/2/3 = punch frame
- busy  out  1  high in any state except IDLE
- hit_active  out  1  high in STRIKE
- punch_done  out  1  one-cycle pulse when COOLDOWN exits

## Operation
- States and frames shown:
  - IDLE: frame 0
  - WINDUP: frame 1
  - EXTEND: frame 2
  - STRIKE: frame 3
  - RETRACT: frame 2
  - COOLDOWN: frame 0
- IDLE → WINDUP on punch_req. tick_cnt clears to 0.
- In each timed state, tick_cnt increments on frame_tick. When frame_tick arrives with tick_cnt == HOLD−1, the block advances to the next state and clears tick_cnt.
- The state order after WINDUP is EXTEND → STRIKE → RETRACT → COOLDOWN.
- COOLDOWN exit:
  - punch_done pulses.
  - If pending is set, go to WINDUP and clear pending.
  - Otherwise go to IDLE.
- Request buffer: a single pending flag.
  - punch_req while busy sets pending.
  - Further requests while pending is set are dropped.
  - A request in IDLE never sets pending.
- punch_req and frame_tick in the same cycle in IDLE: the request is accepted and the tick is not counted (tick_cnt = 0 in WINDUP).
- Compositing:
  - sel_col = colour input chosen by frame_sel.
  - oled_colour ← (sel_col == 16'h0000) ? bg_colour : sel_col.
- frame_sel, busy and hit_active are decoded from the registered state, so they change only on the cycle after a qualifying frame_tick.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, tick_cnt = 0, pending = 0
  - oled_colour = 0, frame_sel = 0
  - busy = 0, hit_active = 0, punch_done = 0
- Reset mid-punch aborts immediately, with no punch_done pulse.
- Pixel latency is 1 clk: oled_colour at edge n+1 reflects the pixel_index, colour inputs and frame_sel sampled at edge n.
- Sprite ROMs are combinational. The frame switch takes effect from the first pixel after the tick, so there is no mid-frame tearing when frame_tick aligns with pixel_index 0.
- Punch duration is the sum of the HOLD_* values in ticks. With defaults, 9 ticks pass from WINDUP entry to punch_done.
- punch_done is asserted in the cycle after the final COOLDOWN tick.
- frame_tick outside timed states is ignored.

## Test plan
- Reset: hold rst_n=0 while asserting punch_req and frame_tick -> all outputs 0. After release, state = IDLE and frame_sel = 0.
- Single punch with defaults: punch_req, then 9 frame_ticks spaced 100 clks apart -> frame_sel sequence 1,1,2,3,3,3,2,0,0,0. hit_active is high for exactly 3 tick intervals. punch_done pulses once, one cycle after tick 9, and busy then drops.
- Buffered request: punch_req during STRIKE, then again during RETRACT -> exactly one extra punch runs immediately after COOLDOWN (frame_sel goes straight 0→1). The second request is dropped, giving 2 punch_done pulses in total.
- Simultaneous req+tick in IDLE -> WINDUP lasts 2 further ticks, not 1.
- Transparency: frame_sel=3, p3_colour=0, bg_colour=16'h001F -> oled_colour=16'h001F one clk later. With p3_colour=16'hF800 -> oled_colour=16'hF800.
- Mid-punch reset during STRIKE -> outputs return to 0 asynchronously, with no punch_done pulse. A new punch_req after release starts at WINDUP.
